// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the 16x-oversampling UART receiver.
//   rx_state_e   - receiver FSM states
//   OVERSAMPLE   - oversample ticks per bit
//   VOTE_IDX*    - sample-counter values at which the line is captured for the vote
//   SCNT_MID/END - mid-bit decision point and last tick of a bit
//   calc_div()   - clock divider for the oversample tick, rounded to nearest
//   maj3()       - 2-of-3 majority vote
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  localparam int unsigned OVERSAMPLE = 16;

  localparam logic [3:0] VOTE_IDX0 = 4'd7;
  localparam logic [3:0] VOTE_IDX1 = 4'd8;
  localparam logic [3:0] VOTE_IDX2 = 4'd9;

  // The third vote sample is taken live at the decision tick itself.
  localparam logic [3:0] SCNT_MID = VOTE_IDX2;
  localparam logic [3:0] SCNT_END = 4'd15;

  // Round-to-nearest divider; never returns 0 so the tick counter stays legal.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    int unsigned rate;
    int unsigned div;
    rate = baud * os;
    div  = (clk_hz + (rate / 32'd2)) / rate;
    if (div == 32'd0) begin
      div = 32'd1;
    end
    return div;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// uart_os_tick: free-running divider producing the 16x oversample strobe.
// Ports:
//   clk     in  system clock
//   rst_n   in  async active-low reset
//   enable  in  0 holds the counter at 0 and suppresses the tick
//   os_tick out one-clk strobe when the count equals DIV-1
module uart_os_tick #(
  parameter int unsigned DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic os_tick
);
  import uart_pkg::*;

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: wrap at DIV-1, forced to zero while disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Divider count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign os_tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 16x-oversampling 8N1 UART receiver with valid/ready output.
// Ports:
//   clk, rst_n  clock and async active-low reset
//   enable      0 parks the receiver in IDLE (handshake keeps working)
//   rx_line     asynchronous serial input, idle high, LSB first
//   data_out    received byte, stable while valid=1
//   valid/ready byte handshake; transfer when both high at posedge clk
//   frame_err   one-clk pulse: stop bit voted 0, byte dropped
//   overrun     one-clk pulse: byte finished while previous one still pending
//   busy        receiver is inside a frame
module uart_rx_os16 #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       rx_line,
  output logic [7:0] data_out,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  import uart_pkg::*;

  localparam int unsigned DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);

  logic os_tick;

  uart_os_tick #(.DIV(DIV)) u_os_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .os_tick (os_tick)
  );

  logic sync1_q;
  logic sync2_q;
  logic rx_s;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_line;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  rx_state_e  state_q,     state_d;
  logic [3:0] scnt_q,      scnt_d;
  logic [2:0] bit_idx_q,   bit_idx_d;
  logic [1:0] samp_q,      samp_d;
  logic [7:0] shift_q,     shift_d;
  logic [7:0] data_q,      data_d;
  logic       valid_q,     valid_d;
  logic       frame_err_q, frame_err_d;
  logic       overrun_q,   overrun_d;
  logic       busy_q,      busy_d;

  logic vote_s;
  logic mid_s;
  logic end_s;

  // Samples from scnt 7 and 8 are stored; the scnt 9 sample is the live line.
  assign vote_s = maj3(samp_q[0], samp_q[1], rx_s);
  assign mid_s  = os_tick && (scnt_q == SCNT_MID);
  assign end_s  = os_tick && (scnt_q == SCNT_END);

  // Next-state logic for the receive FSM and the output handshake.
  always_comb begin
    state_d     = state_q;
    scnt_d      = scnt_q;
    bit_idx_d   = bit_idx_q;
    samp_d      = samp_q;
    shift_d     = shift_q;
    data_d      = data_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    // Consumer acceptance; a byte finishing this same cycle re-raises valid below.
    if (valid_q && ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    if (!enable) begin
      state_d   = RX_IDLE;
      scnt_d    = 4'd0;
      bit_idx_d = 3'd0;
    end else begin
      if (os_tick && (state_q != RX_IDLE)) begin
        scnt_d = scnt_q + 4'd1;
        if (scnt_q == VOTE_IDX0) begin
          samp_d[0] = rx_s;
        end else if (scnt_q == VOTE_IDX1) begin
          samp_d[1] = rx_s;
        end else begin
          samp_d = samp_q;
        end
      end else begin
        scnt_d = scnt_q;
      end

      case (state_q)
        RX_IDLE: begin
          if (os_tick && !rx_s) begin
            state_d = RX_START;
            scnt_d  = 4'd0;
          end else begin
            state_d = RX_IDLE;
          end
        end
        RX_START: begin
          // A start bit that votes high at mid-bit was a glitch.
          if (mid_s && vote_s) begin
            state_d = RX_IDLE;
            scnt_d  = 4'd0;
          end else if (end_s) begin
            state_d   = RX_DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = RX_START;
          end
        end
        RX_DATA: begin
          if (mid_s) begin
            shift_d = {vote_s, shift_q[7:1]};
          end else begin
            shift_d = shift_q;
          end
          if (end_s) begin
            if (bit_idx_q == 3'd7) begin
              state_d = RX_STOP;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end else begin
            state_d = RX_DATA;
          end
        end
        RX_STOP: begin
          // Leave at mid-stop so the next start edge can be caught early.
          if (mid_s) begin
            state_d = RX_IDLE;
            scnt_d  = 4'd0;
            if (vote_s) begin
              if (!valid_q || ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
              end else begin
                overrun_d = 1'b1;
              end
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            state_d = RX_STOP;
          end
        end
        default: begin
          state_d = RX_IDLE;
          scnt_d  = 4'd0;
        end
      endcase
    end

    busy_d = (state_d != RX_IDLE);
  end

  // Receive FSM state, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RX_IDLE;
      scnt_q      <= 4'd0;
      bit_idx_q   <= 3'd0;
      samp_q      <= 2'b11;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      scnt_q      <= scnt_d;
      bit_idx_q   <= bit_idx_d;
      samp_q      <= samp_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_os16.sv
// tb_uart_rx_os16: self-checking bench for uart_rx_os16. A serial driver sends
// 8N1 frames; a negedge monitor collects accepted bytes and error pulses and
// checks handshake stability; a frame-level model predicts the outcome.
module tb_uart_rx_os16;

  localparam int BIT_NS  = 8680;
  localparam int SLOW_NS = 8940;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       enable  = 1'b0;
  logic       rx_line = 1'b1;
  logic       ready   = 1'b0;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int total = 0;
  int bad   = 0;

  int     fe_cnt      = 0;
  int     ov_cnt      = 0;
  int     vcyc        = 0;
  int     busy_rise   = 0;
  longint busy_fall_t = 0;

  logic [7:0] acc_q[$];
  logic [7:0] exp_q[$];

  always #10 clk = ~clk;

  uart_rx_os16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .rx_line   (rx_line),
    .data_out  (data_out),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_queue(input string tag);
    check_eq({tag, "_count"}, acc_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < acc_q.size()) begin
        check_eq(tag, acc_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stop_bit, input int bit_ns);
    rx_line = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      #(bit_ns);
    end
    rx_line = stop_bit;
    #(bit_ns);
    rx_line = 1'b1;
  endtask

  // Monitor: collects events and checks output stability / pulse width.
  logic       v_p  = 1'b0;
  logic       r_p  = 1'b0;
  logic       fe_p = 1'b0;
  logic       ov_p = 1'b0;
  logic       b_p  = 1'b0;
  logic [7:0] d_p  = 8'h00;

  always @(negedge clk) begin
    if (rst_n) begin
      if (v_p && !r_p) begin
        check_eq("hold_valid", valid, 1);
        check_eq("hold_data", data_out, d_p);
      end
      if (fe_p) check_eq("fe_width", frame_err, 0);
      if (ov_p) check_eq("ov_width", overrun, 0);
      if (valid && ready) acc_q.push_back(data_out);
      if (valid) vcyc <= vcyc + 1;
      if (frame_err) fe_cnt <= fe_cnt + 1;
      if (overrun) ov_cnt <= ov_cnt + 1;
      if (busy && !b_p) busy_rise <= busy_rise + 1;
      if (!busy && b_p) busy_fall_t <= $time;
    end
    v_p  <= valid;
    r_p  <= ready;
    fe_p <= frame_err;
    ov_p <= overrun;
    b_p  <= busy;
    d_p  <= data_out;
  end

  initial begin
    int         fe0;
    int         ov0;
    int         vc0;
    int         br0;
    int         exp_fe;
    longint     t0;
    longint     dt;
    logic [7:0] b;
    logic       sb;
    int         bn;

    // Reset values
    #55;
    check_eq("rst_data", data_out, 8'h00);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_fe", frame_err, 0);
    check_eq("rst_ov", overrun, 0);
    check_eq("rst_busy", busy, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;
    ready  = 1'b1;
    #(2 * BIT_NS);

    // Basic byte with ready held high
    acc_q.delete(); exp_q.delete();
    fe0 = fe_cnt; ov0 = ov_cnt; vc0 = vcyc;
    exp_q.push_back(8'hB3);
    t0 = $time;
    send(8'hB3, 1'b1, BIT_NS);
    #(BIT_NS);
    check_queue("t1_byte");
    check_eq("t1_valid_cycles", vcyc - vc0, 1);
    check_eq("t1_fe", fe_cnt - fe0, 0);
    check_eq("t1_ov", ov_cnt - ov0, 0);
    dt = busy_fall_t - t0;
    check_eq("t1_busy_fall", (dt >= 9 * BIT_NS) && (dt <= 10 * BIT_NS), 1);
    check_eq("t1_data_kept", data_out, 8'hB3);

    // Short low glitch: false start
    acc_q.delete();
    fe0 = fe_cnt; br0 = busy_rise;
    rx_line = 1'b0;
    #3000;
    rx_line = 1'b1;
    #(2 * BIT_NS);
    check_eq("t2_busy_seen", busy_rise - br0, 1);
    check_eq("t2_busy_now", busy, 0);
    check_eq("t2_nobyte", acc_q.size(), 0);
    check_eq("t2_fe", fe_cnt - fe0, 0);
    check_eq("t2_valid", valid, 0);

    // Stop bit driven low: framing error
    acc_q.delete();
    fe0 = fe_cnt; ov0 = ov_cnt;
    send(8'h5A, 1'b0, BIT_NS);
    #(2 * BIT_NS);
    check_eq("t3_fe", fe_cnt - fe0, 1);
    check_eq("t3_valid", valid, 0);
    check_eq("t3_data_kept", data_out, 8'hB3);
    check_eq("t3_nobyte", acc_q.size(), 0);
    check_eq("t3_ov", ov_cnt - ov0, 0);

    // Backpressure and overrun
    acc_q.delete();
    fe0 = fe_cnt; ov0 = ov_cnt;
    ready = 1'b0;
    send(8'h11, 1'b1, BIT_NS);
    #(BIT_NS);
    check_eq("t4_valid1", valid, 1);
    check_eq("t4_data1", data_out, 8'h11);
    send(8'h22, 1'b1, BIT_NS);
    #(BIT_NS);
    check_eq("t4_ov", ov_cnt - ov0, 1);
    check_eq("t4_fe", fe_cnt - fe0, 0);
    check_eq("t4_valid2", valid, 1);
    check_eq("t4_data2", data_out, 8'h11);
    @(posedge clk); #1;
    ready = 1'b1;
    @(posedge clk); #1;
    check_eq("t4_valid_drop", valid, 0);
    check_eq("t4_data_after", data_out, 8'h11);
    exp_q.delete();
    exp_q.push_back(8'h11);
    check_queue("t4_accept");

    // Slow transmitter (+3%) and back-to-back frames
    acc_q.delete(); exp_q.delete();
    fe0 = fe_cnt; ov0 = ov_cnt;
    exp_q.push_back(8'hA5); exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
    send(8'hA5, 1'b1, SLOW_NS);
    #(SLOW_NS);
    send(8'h00, 1'b1, SLOW_NS);
    send(8'hFF, 1'b1, SLOW_NS);
    #(SLOW_NS);
    check_queue("t5_bytes");
    check_eq("t5_fe", fe_cnt - fe0, 0);
    check_eq("t5_ov", ov_cnt - ov0, 0);

    // Reset in the middle of a frame
    acc_q.delete(); exp_q.delete();
    b = 8'h3C;
    rx_line = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx_line = b[i];
      #(BIT_NS);
    end
    rx_line = b[4];
    #(BIT_NS / 2);
    check_eq("t6_busy_pre", busy, 1);
    rst_n = 1'b0;
    #50;
    check_eq("t6_rst_data", data_out, 8'h00);
    check_eq("t6_rst_valid", valid, 0);
    check_eq("t6_rst_busy", busy, 0);
    check_eq("t6_rst_fe", frame_err, 0);
    check_eq("t6_rst_ov", overrun, 0);
    #50;
    rst_n   = 1'b1;
    rx_line = 1'b1;
    #(3 * BIT_NS);
    fe0 = fe_cnt; ov0 = ov_cnt;
    exp_q.push_back(8'hC3);
    send(8'hC3, 1'b1, BIT_NS);
    #(BIT_NS);
    check_queue("t6_bytes");
    check_eq("t6_fe", fe_cnt - fe0, 0);
    check_eq("t6_ov", ov_cnt - ov0, 0);

    // Random frames against the frame-level model
    acc_q.delete(); exp_q.delete();
    fe0 = fe_cnt; ov0 = ov_cnt;
    exp_fe = 0;
    for (int k = 0; k < 4; k++) begin
      b  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 3) != 0);
      bn = int'($urandom_range(8520, 8840));
      if (sb) exp_q.push_back(b);
      else    exp_fe++;
      send(b, sb, bn);
      #(2 * bn);
    end
    check_queue("rnd_bytes");
    check_eq("rnd_fe", fe_cnt - fe0, exp_fe);
    check_eq("rnd_ov", ov_cnt - ov0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
